// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: registered issue/capture wrapper around the combinational FPU add/sub.
// Requests are accepted on a valid/ready handshake, and the operands are held in registers that
// drive the FPU. After WAIT_CYC cycles the FPU result is sampled and offered on a valid/ready
// result handshake.
// Optional build macro FPU_FLAGS_EN adds o_res_flags = {nan, inf, zero, sign}. The flags are
// decoded from the sampled result and registered on the same edge as o_res_data.
module fpu_issue_ctrl #(
   parameter int unsigned NUM_OP   = 1,
   parameter int unsigned WAIT_CYC = 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic [NUM_OP-1:0] i_req_op,
   input  logic [31:0]       i_req_a,
   input  logic [31:0]       i_req_b,
   output logic [NUM_OP-1:0] o_fpu_op,
   output logic [31:0]       o_fpu_a,
   output logic [31:0]       o_fpu_b,
   input  logic [31:0]       i_fpu_result,
   output logic              o_res_valid,
   input  logic              i_res_ready,
   output logic [31:0]       o_res_data,
`ifdef FPU_FLAGS_EN
   output logic [3:0]        o_res_flags,
`endif
   output logic              o_busy
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StExec = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   localparam logic [3:0] CntLoad = 4'(WAIT_CYC - 1);

   logic [1:0]        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              res_valid_q, res_valid_d;
   logic [NUM_OP-1:0] fpu_op_q;
   logic [31:0]       fpu_a_q, fpu_b_q, res_data_q;
   logic              load, capture, req_fire;

   // Ready depends only on state, except in DONE where it follows the result consumer
   // so that a new request can be accepted in the same cycle the result drains.
   always_comb begin
      o_req_ready = 1'b0;
      case (state_q)
         StIdle:  o_req_ready = 1'b1;
         StDone:  o_req_ready = i_res_ready;
         default: o_req_ready = 1'b0;
      endcase
   end

   assign req_fire = i_req_valid & o_req_ready;

   // Next-state, counter and load/capture strobes
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      res_valid_d = res_valid_q;
      load        = 1'b0;
      capture     = 1'b0;
      case (state_q)
         StIdle: begin
            if (req_fire) begin
               load    = 1'b1;
               cnt_d   = CntLoad;
               state_d = StExec;
            end
         end
         StExec: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               capture     = 1'b1;
               res_valid_d = 1'b1;
               state_d     = StDone;
            end
         end
         StDone: begin
            if (i_res_ready) begin
               res_valid_d = 1'b0;
               if (req_fire) begin
                  // Back-to-back issue, no IDLE bubble
                  load    = 1'b1;
                  cnt_d   = CntLoad;
                  state_d = StExec;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State, counter and result-valid registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= 4'd0;
         res_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         res_valid_q <= res_valid_d;
      end
   end

   // Operand registers feeding the FPU, which change only on a request transfer
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         fpu_op_q <= '0;
         fpu_a_q  <= 32'd0;
         fpu_b_q  <= 32'd0;
      end else if (load) begin
         fpu_op_q <= i_req_op;
         fpu_a_q  <= i_req_a;
         fpu_b_q  <= i_req_b;
      end
   end

   // Result register, sampled once when the settle interval expires
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         res_data_q <= 32'd0;
      end else if (capture) begin
         res_data_q <= i_fpu_result;
      end
   end

`ifdef FPU_FLAGS_EN
   logic [3:0] flags_d, flags_q;

   // Classify the raw FPU result as {nan, inf, zero, sign}
   always_comb begin
      flags_d    = 4'd0;
      flags_d[3] = (i_fpu_result[30:23] == 8'hFF) && (i_fpu_result[22:0] != 23'd0);
      flags_d[2] = (i_fpu_result[30:23] == 8'hFF) && (i_fpu_result[22:0] == 23'd0);
      flags_d[1] = (i_fpu_result[30:0] == 31'd0);
      flags_d[0] = i_fpu_result[31];
   end

   // Flags are captured alongside the result data
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         flags_q <= 4'd0;
      end else if (capture) begin
         flags_q <= flags_d;
      end
   end

   assign o_res_flags = flags_q;
`endif

   assign o_fpu_op    = fpu_op_q;
   assign o_fpu_a     = fpu_a_q;
   assign o_fpu_b     = fpu_b_q;
   assign o_res_valid = res_valid_q;
   assign o_res_data  = res_data_q;
   assign o_busy      = (state_q == StExec) || (state_q == StDone);

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed testbench for fpu_issue_ctrl.
// It uses two instances: one with a 1-cycle settle interval and one with a 4-cycle interval.
// A small lookup table stands in for the FPU add/sub datapath.
module tb_fpu_issue_ctrl;

   logic        clk;
   logic        rst_n;
   logic        v1, v4;
   logic        op;
   logic [31:0] a, b;
   logic        res_ready;

   logic        r1_ready, r4_ready, r1_valid, r4_valid, r1_busy, r4_busy;
   logic        f1_op, f4_op;
   logic [31:0] f1_a, f1_b, f4_a, f4_b, res1, res4, d1, d4;
`ifdef FPU_FLAGS_EN
   logic [3:0]  fl1, fl4;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   // Stand-in for the combinational FPU: known vectors only
   function automatic logic [31:0] fpu_model(input logic o, input logic [31:0] x,
                                             input logic [31:0] y);
      if (!o && x == 32'h40B00000 && y == 32'h400CCCCD) return 32'h40F66666;
      if ( o && x == 32'h40B00000 && y == 32'h400CCCCD) return 32'h40533333;
      if (!o && x == 32'hC0B00000 && y == 32'hC00CCCCD) return 32'hC0F66666;
      return 32'hDEADBEEF;
   endfunction

   assign res1 = fpu_model(f1_op, f1_a, f1_b);
   assign res4 = fpu_model(f4_op, f4_a, f4_b);

   fpu_issue_ctrl #(.NUM_OP(1), .WAIT_CYC(1)) u1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(v1), .o_req_ready(r1_ready),
      .i_req_op(op), .i_req_a(a), .i_req_b(b), .o_fpu_op(f1_op), .o_fpu_a(f1_a),
      .o_fpu_b(f1_b), .i_fpu_result(res1), .o_res_valid(r1_valid), .i_res_ready(res_ready),
      .o_res_data(d1),
`ifdef FPU_FLAGS_EN
      .o_res_flags(fl1),
`endif
      .o_busy(r1_busy)
   );

   fpu_issue_ctrl #(.NUM_OP(1), .WAIT_CYC(4)) u4 (
      .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(v4), .o_req_ready(r4_ready),
      .i_req_op(op), .i_req_a(a), .i_req_b(b), .o_fpu_op(f4_op), .o_fpu_a(f4_a),
      .o_fpu_b(f4_b), .i_fpu_result(res4), .o_res_valid(r4_valid), .i_res_ready(res_ready),
      .o_res_data(d4),
`ifdef FPU_FLAGS_EN
      .o_res_flags(fl4),
`endif
      .o_busy(r4_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; v1 = 1'b0; v4 = 1'b0; op = 1'b0; a = 32'd0; b = 32'd0; res_ready = 1'b0;
      tick(); tick();
      check("rst_valid", r1_valid, 0);
      check("rst_ready", r1_ready, 1);
      check("rst_fpu_a", f1_a, 0);
      check("rst_fpu_b", f1_b, 0);
      check("rst_busy", r1_busy, 0);
      check("rst_data", d1, 0);
      check("rst_ready4", r4_ready, 1);
      rst_n = 1'b1;
      tick();

      // Add, WAIT_CYC=1: the transfer edge counts as the first of two edges
      op = 1'b0; a = 32'h40B00000; b = 32'h400CCCCD; res_ready = 1'b1; v1 = 1'b1;
      tick();
      v1 = 1'b0;
      check("add_exec_valid", r1_valid, 0);
      check("add_exec_ready", r1_ready, 0);
      check("add_exec_busy", r1_busy, 1);
      check("add_fpu_a", f1_a, 32'h40B00000);
      check("add_fpu_b", f1_b, 32'h400CCCCD);
      tick();
      check("add_valid", r1_valid, 1);
      check("add_data", d1, 32'h40F66666);
      tick();
      check("add_drain_valid", r1_valid, 0);
      check("add_drain_busy", r1_busy, 0);
      check("add_keep_fpu_a", f1_a, 32'h40B00000);

      // Sub with backpressure
      res_ready = 1'b0; op = 1'b1; v1 = 1'b1;
      tick();
      v1 = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         check("sub_bp_valid", r1_valid, 1);
         check("sub_bp_data", d1, 32'h40533333);
         check("sub_bp_ready", r1_ready, 0);
         tick();
      end
      res_ready = 1'b1;
      #1;
      check("sub_ready_follow", r1_ready, 1);
      tick();
      check("sub_drain_valid", r1_valid, 0);
      check("sub_drain_busy", r1_busy, 0);

      // Back-to-back: reach DONE, then a request and the result drain on the same edge
      res_ready = 1'b0; op = 1'b1; a = 32'h40B00000; b = 32'h400CCCCD; v1 = 1'b1;
      tick();
      v1 = 1'b0;
      tick();
      check("b2b_first", d1, 32'h40533333);
      res_ready = 1'b1; op = 1'b0; a = 32'hC0B00000; b = 32'hC00CCCCD; v1 = 1'b1;
      tick();
      v1 = 1'b0;
      check("b2b_valid_clr", r1_valid, 0);
      check("b2b_no_idle", r1_busy, 1);
      check("b2b_fpu_a", f1_a, 32'hC0B00000);
      tick();
      check("b2b_valid", r1_valid, 1);
      check("b2b_data", d1, 32'hC0F66666);
`ifdef FPU_FLAGS_EN
      check("b2b_flags", {28'd0, fl1}, 32'h1);
`endif
      tick();
      check("b2b_idle", r1_busy, 0);

      // WAIT_CYC=4 with the request held high during EXEC
      op = 1'b0; a = 32'h40B00000; b = 32'h400CCCCD; res_ready = 1'b1; v4 = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         check("w4_ready", r4_ready, 0);
         check("w4_valid", r4_valid, 0);
         check("w4_fpu_a", f4_a, 32'h40B00000);
         tick();
      end
      v4 = 1'b0;
      check("w4_res_valid", r4_valid, 1);
      check("w4_res_data", d4, 32'h40F66666);
      tick();
      check("w4_idle", r4_busy, 0);

      // Mid-op reset in EXEC, then a normal operation
      op = 1'b1; v4 = 1'b1;
      tick();
      v4 = 1'b0;
      tick();
      check("mid_busy", r4_busy, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", r4_valid, 0);
      check("mid_rst_fpu_a", f4_a, 0);
      check("mid_rst_op", f4_op, 0);
      check("mid_rst_busy", r4_busy, 0);
      check("mid_rst_ready", r4_ready, 1);
      tick();
      rst_n = 1'b1;
      tick();
      op = 1'b0; v4 = 1'b1;
      tick();
      v4 = 1'b0;
      tick(); tick(); tick();
      check("post_rst_early", r4_valid, 0);
      tick();
      check("post_rst_valid", r4_valid, 1);
      check("post_rst_data", d4, 32'h40F66666);

      // Reset while in DONE: valid must fall without a clock edge
      res_ready = 1'b0; op = 1'b0; v1 = 1'b1;
      tick();
      v1 = 1'b0;
      tick();
      check("done_valid", r1_valid, 1);
      rst_n = 1'b0;
      #1;
      check("done_rst_valid", r1_valid, 0);
      check("done_rst_data", d1, 0);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
